// File: rtl/serdes_pkg.sv
// Shared SerDes constants: word width, K28.5 comma patterns,
// and the receive alignment state type.
package serdes_pkg;

    localparam int WORD_W = 10;

    // Patterns are in received-bit order: bit 0 arrives first.
    localparam logic [WORD_W-1:0] K28_5_RDN = 10'h17C;
    localparam logic [WORD_W-1:0] K28_5_RDP = 10'h283;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } sipo_state_t;

endpackage

// File: rtl/comma_detect.sv
// Combinational K28.5 comma matcher over a 10-bit window,
// either running disparity.
module comma_detect
    import serdes_pkg::*;
#(
    parameter logic [WORD_W-1:0] COMMA_P = K28_5_RDN,
    parameter logic [WORD_W-1:0] COMMA_N = K28_5_RDP
) (
    input  logic [WORD_W-1:0] win,
    output logic              match
);

    assign match = (win == COMMA_P) || (win == COMMA_N);

endmodule

// File: rtl/sipo_10bit_align.sv
// LSB-first 10-bit deserializer with comma word alignment.
// SIPO_REALIGN_CNT_EN adds a saturating realign event counter.
module sipo_10bit_align
    import serdes_pkg::*;
#(
    parameter logic [WORD_W-1:0] COMMA_P = K28_5_RDN,
    parameter logic [WORD_W-1:0] COMMA_N = K28_5_RDP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ser_in,
    input  logic              align_en,
    output logic [WORD_W-1:0] par_out,
    output logic              par_valid,
    output logic              locked,
    output logic              comma_det
`ifdef SIPO_REALIGN_CNT_EN
   ,output logic [7:0]        realign_cnt
`endif
);

    localparam logic [3:0] LAST_BIT = 4'd9;

    logic [WORD_W-1:0] shift_reg;
    logic [WORD_W-1:0] win;
    logic [3:0]        bit_cnt;
    sipo_state_t       state;
    logic              match;
    logic              word_end;
    logic              realign_evt;

    // New bit enters at the MSB so the oldest bit sits at bit 0.
    assign win = {ser_in, shift_reg[WORD_W-1:1]};

    comma_detect #(
        .COMMA_P (COMMA_P),
        .COMMA_N (COMMA_N)
    ) u_comma_detect (
        .win   (win),
        .match (match)
    );

    assign locked      = (state == LOCKED);
    assign word_end    = (bit_cnt == LAST_BIT);
    assign realign_evt = locked && !word_end && match && align_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_reg <= '0;
            par_out   <= '0;
            bit_cnt   <= '0;
            par_valid <= 1'b0;
            comma_det <= 1'b0;
            state     <= HUNT;
        end else begin
            shift_reg <= win;
            par_valid <= 1'b0;
            comma_det <= 1'b0;
            unique case (state)
                HUNT: begin
                    if (match && align_en) begin
                        par_out   <= win;
                        par_valid <= 1'b1;
                        comma_det <= 1'b1;
                        bit_cnt   <= '0;
                        state     <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (word_end) begin
                        par_out   <= win;
                        par_valid <= 1'b1;
                        comma_det <= match;
                        bit_cnt   <= '0;
                    end else if (realign_evt) begin
                        // Misaligned comma: drop the partial word.
                        par_out   <= win;
                        par_valid <= 1'b1;
                        comma_det <= 1'b1;
                        bit_cnt   <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

`ifdef SIPO_REALIGN_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            realign_cnt <= '0;
        end else if (realign_evt && (realign_cnt != 8'hFF)) begin
            realign_cnt <= realign_cnt + 8'd1;
        end
    end
`endif

endmodule
